esc_pwm_capture: RTL and testbench

//  Decoder for ESC/RC-style PWM command pulses (1-2 ms high, ~20 ms frame) arriving on one pin.

---
 rtl/esc_pwm_capture_if.sv | 23 ++
 rtl/esc_pwm_capture.sv | 169 ++++++++++++++++
 tb/tb_esc_pwm_capture.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/esc_pwm_capture_if.sv
// PWM capture bus: raw pin in, decoded throttle and status out.
// Master side is the decoder; slave side is the consumer/driver of the pin.
interface esc_pwm_capture_if #(
   parameter int CNT_W = 16,
   parameter int OUT_W = 11
);
   logic             pwm_in;
   logic [OUT_W-1:0] throttle;
   logic [CNT_W-1:0] high_ticks;
   logic             meas_valid;
   logic             err_pulse;
   logic             signal_lost;

   modport master (
      input  pwm_in,
      output throttle, high_ticks, meas_valid, err_pulse, signal_lost
   );

   modport slave (
      output pwm_in,
      input  throttle, high_ticks, meas_valid, err_pulse, signal_lost
   );
endinterface

// File: rtl/esc_pwm_capture.sv
// ESC PWM decoder: pulse high time in ticks -> clamped throttle, glitch reject, loss-of-signal.
// Results appear 2 clk after the falling edge is detected (3 clk sync); no backpressure, strobes only.
module esc_pwm_capture #(
   parameter int TICK_DIV = 25,
   parameter int CNT_W    = 16,
   parameter int MIN_HIGH = 1000,
   parameter int MAX_HIGH = 2000,
   parameter int VALID_LO = 500,
   parameter int VALID_HI = 2500,
   parameter int TIMEOUT  = 25000,
   parameter int OUT_W    = 11
) (
   input logic               clk,
   input logic               rst,
   esc_pwm_capture_if.master bus
);

   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] VLO      = CNT_W'(VALID_LO);
   localparam logic [CNT_W-1:0] VHI      = CNT_W'(VALID_HI);
   localparam logic [CNT_W-1:0] MINH     = CNT_W'(MIN_HIGH);
   localparam logic [CNT_W-1:0] MAXH     = CNT_W'(MAX_HIGH);
   localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [OUT_W-1:0] SPAN     = OUT_W'(MAX_HIGH - MIN_HIGH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT_RISE, S_HIGH, S_LOW} state_t;

   logic             sync1_q, sync2_q, edge_q;
   logic [1:0]       primed_q;
   logic [PRE_W-1:0] pre_q, pre_d;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
   logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
   logic             eval_q, eval_d;
   logic [OUT_W-1:0] throttle_q, throttle_d;
   logic [CNT_W-1:0] high_ticks_q, high_ticks_d;
   logic             meas_valid_q, meas_valid_d;
   logic             err_pulse_q, err_pulse_d;
   logic             signal_lost_q, signal_lost_d;

   logic             tick, rise, fall, timeout;
   logic [CNT_W-1:0] excess;

   // primed_q marks when sync2_q reflects the pin rather than its reset value
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         edge_q   <= 1'b0;
         primed_q <= '0;
      end else begin
         sync1_q  <= bus.pwm_in;
         sync2_q  <= sync1_q;
         edge_q   <= sync2_q;
         primed_q <= {primed_q[0], 1'b1};
      end
   end

   always_comb begin
      tick    = (pre_q == PRE_LAST);
      rise    = sync2_q & ~edge_q;
      fall    = ~sync2_q & edge_q;
      timeout = (state_q != S_IDLE) && !rise && (to_cnt_q >= TMO);
      excess  = hi_cnt_q - MINH;

      pre_d         = tick ? '0 : pre_q + 1'b1;
      state_d       = state_q;
      hi_cnt_d      = hi_cnt_q;
      to_cnt_d      = to_cnt_q;
      eval_d        = 1'b0;
      throttle_d    = throttle_q;
      high_ticks_d  = high_ticks_q;
      meas_valid_d  = 1'b0;
      err_pulse_d   = 1'b0;
      signal_lost_d = signal_lost_q;

      if (state_q != S_IDLE && tick && to_cnt_q != CNT_MAX) begin
         to_cnt_d = to_cnt_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (primed_q[1] && !sync2_q) begin
               state_d = S_WAIT_RISE;
            end
         end
         S_WAIT_RISE, S_LOW: begin
            if (rise) begin
               hi_cnt_d = '0;
               to_cnt_d = '0;
               state_d  = S_HIGH;
            end
         end
         S_HIGH: begin
            if (fall) begin
               state_d = S_LOW;
               eval_d  = 1'b1;
            end else if (tick && hi_cnt_q != CNT_MAX) begin
               hi_cnt_d = hi_cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (eval_q) begin
         if (hi_cnt_q >= VLO && hi_cnt_q <= VHI) begin
            high_ticks_d  = hi_cnt_q;
            meas_valid_d  = 1'b1;
            signal_lost_d = 1'b0;
            if (hi_cnt_q <= MINH) begin
               throttle_d = '0;
            end else if (hi_cnt_q >= MAXH) begin
               throttle_d = SPAN;
            end else begin
               throttle_d = OUT_W'(excess);
            end
         end else begin
            err_pulse_d = 1'b1;
         end
      end

      // Loss of signal overrides any result evaluated in the same cycle
      if (timeout) begin
         signal_lost_d = 1'b1;
         throttle_d    = '0;
         high_ticks_d  = '0;
         meas_valid_d  = 1'b0;
         err_pulse_d   = 1'b0;
         eval_d        = 1'b0;
         to_cnt_d      = '0;
         state_d       = S_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q         <= '0;
         state_q       <= S_IDLE;
         hi_cnt_q      <= '0;
         to_cnt_q      <= '0;
         eval_q        <= 1'b0;
         throttle_q    <= '0;
         high_ticks_q  <= '0;
         meas_valid_q  <= 1'b0;
         err_pulse_q   <= 1'b0;
         signal_lost_q <= 1'b0;
      end else begin
         pre_q         <= pre_d;
         state_q       <= state_d;
         hi_cnt_q      <= hi_cnt_d;
         to_cnt_q      <= to_cnt_d;
         eval_q        <= eval_d;
         throttle_q    <= throttle_d;
         high_ticks_q  <= high_ticks_d;
         meas_valid_q  <= meas_valid_d;
         err_pulse_q   <= err_pulse_d;
         signal_lost_q <= signal_lost_d;
      end
   end

   assign bus.throttle    = throttle_q;
   assign bus.high_ticks  = high_ticks_q;
   assign bus.meas_valid  = meas_valid_q;
   assign bus.err_pulse   = err_pulse_q;
   assign bus.signal_lost = signal_lost_q;

endmodule

// File: tb/tb_esc_pwm_capture.sv
// Bench for esc_pwm_capture with timing scaled down 10x (3 clk per tick) to keep runs short.
// Expected results are queued per driven pulse and compared when the decoder strobes.
module tb_esc_pwm_capture;

   localparam int TD   = 3;
   localparam int CW   = 16;
   localparam int OW   = 11;
   localparam int MINH = 100;
   localparam int MAXH = 200;
   localparam int VLO  = 50;
   localparam int VHI  = 250;
   localparam int TMO  = 2500;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   typedef struct {
      int kind;      // 1 = accepted, 2 = rejected
      int thr;
      int thr_tol;
      int ticks;
      int ticks_tol;
   } exp_t;

   exp_t sb[$];
   int   last_thr = 0, last_thr_tol = 0, last_ticks = 0, last_ticks_tol = 0;

   esc_pwm_capture_if #(.CNT_W(CW), .OUT_W(OW)) bus_if ();

   esc_pwm_capture #(
      .TICK_DIV(TD), .CNT_W(CW), .MIN_HIGH(MINH), .MAX_HIGH(MAXH),
      .VALID_LO(VLO), .VALID_HI(VHI), .TIMEOUT(TMO), .OUT_W(OW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #20 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int obs, input int exp, input int tol = 0);
      int d;
      d = obs - exp;
      total++;
      if (d < -tol || d > tol) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (+/-%0d)", tag, obs, exp, tol);
      end
   endtask

   task automatic wait_ticks(input int n);
      repeat (n * TD) @(posedge clk);
      #1;
   endtask

   task automatic push_pulse(input int p);
      exp_t e;
      if (p < VLO || p > VHI) begin
         e.kind = 2;
         e.thr = last_thr;     e.thr_tol = last_thr_tol;
         e.ticks = last_ticks; e.ticks_tol = last_ticks_tol;
      end else begin
         e.kind = 1;
         e.ticks = p; e.ticks_tol = 1;
         if (p <= MINH) begin
            e.thr = 0; e.thr_tol = 0;
         end else if (p > MAXH) begin
            e.thr = MAXH - MINH; e.thr_tol = 0;
         end else begin
            e.thr = p - MINH; e.thr_tol = 1;
         end
         last_thr = e.thr; last_thr_tol = e.thr_tol;
         last_ticks = e.ticks; last_ticks_tol = e.ticks_tol;
      end
      sb.push_back(e);
   endtask

   task automatic model_cleared();
      last_thr = 0; last_thr_tol = 0; last_ticks = 0; last_ticks_tol = 0;
   endtask

   task automatic pulse(input int hi, input int frame);
      push_pulse(hi);
      bus_if.pwm_in = 1'b1;
      wait_ticks(hi);
      bus_if.pwm_in = 1'b0;
      wait_ticks(frame - hi);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      int   kind_obs;
      if (!rst && (bus_if.meas_valid || bus_if.err_pulse)) begin
         kind_obs = bus_if.meas_valid ? (bus_if.err_pulse ? 3 : 1) : 2;
         check("sb_nonempty", (sb.size() > 0) ? 1 : 0, 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("strobe_kind", kind_obs, e.kind);
            check("throttle", int'(bus_if.throttle), e.thr, e.thr_tol);
            check("high_ticks", int'(bus_if.high_ticks), e.ticks, e.ticks_tol);
            if (e.kind == 1) check("lost_clr_on_valid", int'(bus_if.signal_lost), 0);
         end
      end
   end

   initial begin : watchdog
      #(100000 * 40);
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int t0;
      int waited;
      bus_if.pwm_in = 1'b0;
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("rst_throttle", int'(bus_if.throttle), 0);
      check("rst_high_ticks", int'(bus_if.high_ticks), 0);
      check("rst_meas_valid", int'(bus_if.meas_valid), 0);
      check("rst_err_pulse", int'(bus_if.err_pulse), 0);
      check("rst_signal_lost", int'(bus_if.signal_lost), 0);
      rst = 1'b0;
      wait_ticks(10);

      // nominal frames
      for (int i = 0; i < 3; i++) pulse(150, 1000);
      // clamping below and above the range
      pulse(90, 1000);
      pulse(220, 1000);
      // glitch after a good pulse
      pulse(150, 500);
      pulse(20, 1000);
      check("glitch_keeps_throttle", int'(bus_if.throttle), 50, 1);

      // line held low after a pulse: loss of signal from the last rising edge
      push_pulse(150);
      bus_if.pwm_in = 1'b1;
      t0 = cyc;
      wait_ticks(150);
      bus_if.pwm_in = 1'b0;
      waited = 0;
      while (!bus_if.signal_lost && waited < 3000 * TD) begin
         @(posedge clk);
         #1;
         waited++;
      end
      check("lost_time", cyc - t0, TMO * TD, 3 * TD);
      check("lost_level", int'(bus_if.signal_lost), 1);
      check("lost_throttle", int'(bus_if.throttle), 0);
      check("lost_high_ticks", int'(bus_if.high_ticks), 0);
      model_cleared();
      wait_ticks(100);
      pulse(150, 1000);
      check("recover_lost", int'(bus_if.signal_lost), 0);
      check("recover_throttle", int'(bus_if.throttle), 50, 1);

      // line stuck high
      bus_if.pwm_in = 1'b1;
      wait_ticks(3000);
      check("stuck_lost", int'(bus_if.signal_lost), 1);
      check("stuck_throttle", int'(bus_if.throttle), 0);
      model_cleared();
      bus_if.pwm_in = 1'b0;
      wait_ticks(500);
      pulse(120, 1000);
      check("stuck_recover_lost", int'(bus_if.signal_lost), 0);
      check("stuck_recover_throttle", int'(bus_if.throttle), 20, 1);

      // reset in the middle of a pulse
      bus_if.pwm_in = 1'b1;
      wait_ticks(60);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_throttle", int'(bus_if.throttle), 0);
      check("midrst_high_ticks", int'(bus_if.high_ticks), 0);
      check("midrst_lost", int'(bus_if.signal_lost), 0);
      model_cleared();
      wait_ticks(90);
      bus_if.pwm_in = 1'b0;
      wait_ticks(900);
      check("midrst_no_report", int'(bus_if.throttle), 0);
      pulse(150, 1000);

      wait_ticks(10);
      check("sb_leftover", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
